// File: rtl/risc_boot_pkg.sv
// Shared types and constants for the RISC boot/run controller.
// Optional breakpoint support is enabled with BOOT_BREAKPOINT_EN.
package risc_boot_pkg;

    localparam int DEF_ADDR_W  = 10;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_CNT_W   = 32;
    localparam int DEF_TIMEOUT = 2000;

    // Opcode of the core's HLT instruction.
    localparam logic [5:0] HLT_OP = 6'h3f;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        DONE,
        TMO,
        BRK
    } state_t;

endpackage

// File: rtl/risc_boot_cnt.sv
// Saturating cycle counter with enable, clear and terminal compare.
// term flags cnt == TERM-1; TERM of 0 never flags.
module risc_boot_cnt #(
    parameter int W    = 32,
    parameter int TERM = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         term
);

    // Count enabled cycles, stick at all-ones, clear on request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign term = (TERM != 0) && (cnt == W'(TERM - 1));

endmodule

// File: rtl/risc_boot_ctrl.sv
// Boot and run controller: streams a program into imem, runs the core,
// reports HLT/timeout/overflow. BOOT_BREAKPOINT_EN adds a PC breakpoint.
module risc_boot_ctrl
    import risc_boot_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              start,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              core_run,
    input  logic              core_halted,
    output logic              done,
    output logic              timeout,
    output logic              overflow,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [ADDR_W:0]   word_count
`ifdef BOOT_BREAKPOINT_EN
    ,
    input  logic              bp_en,
    input  logic [ADDR_W-1:0] bp_addr,
    input  logic [ADDR_W-1:0] core_pc,
    output logic              bp_hit
`endif
);

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic              xfer;
    logic              restart;
    logic              run_en;
    logic              at_end;
    logic              term;
    logic              bp_trig;

    assign xfer    = ld_valid && ld_ready;
    assign at_end  = (addr == '1);
    assign run_en  = (state == RUN) && !core_halted;
    assign restart = start &&
                     ((state == IDLE) || (state == DONE) || (state == TMO));

`ifdef BOOT_BREAKPOINT_EN
    assign bp_trig = bp_en && (core_pc == bp_addr);
`else
    assign bp_trig = 1'b0;
`endif

    risc_boot_cnt #(
        .W    (CNT_W),
        .TERM (TIMEOUT)
    ) u_cnt (
        .clk  (clk1),
        .rst  (rst),
        .clr  (restart),
        .en   (run_en),
        .cnt  (cycle_count),
        .term (term)
    );

    // Session FSM; every output is registered alongside the state.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            addr       <= '0;
            ld_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            core_run   <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
            overflow   <= 1'b0;
            word_count <= '0;
`ifdef BOOT_BREAKPOINT_EN
            bp_hit     <= 1'b0;
`endif
        end else begin
            imem_we <= xfer;
            if (xfer) begin
                imem_addr  <= addr;
                imem_wdata <= ld_data;
            end
            unique case (state)
                IDLE, DONE, TMO: begin
                    if (start) begin
                        state      <= LOAD;
                        ld_ready   <= 1'b1;
                        addr       <= '0;
                        word_count <= '0;
                        done       <= 1'b0;
                        timeout    <= 1'b0;
                        overflow   <= 1'b0;
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        word_count <= word_count + 1'b1;
                        if (!at_end) begin
                            addr <= addr + 1'b1;
                        end
                        if (ld_last) begin
                            state    <= RUN;
                            ld_ready <= 1'b0;
                            core_run <= 1'b1;
                        end else if (at_end) begin
                            state    <= TMO;
                            ld_ready <= 1'b0;
                            overflow <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (core_halted) begin
                        state    <= DONE;
                        core_run <= 1'b0;
                        done     <= 1'b1;
                    end else if (bp_trig) begin
`ifdef BOOT_BREAKPOINT_EN
                        state    <= BRK;
                        core_run <= 1'b0;
                        bp_hit   <= 1'b1;
`endif
                    end else if (term) begin
                        state    <= TMO;
                        core_run <= 1'b0;
                        timeout  <= 1'b1;
                    end
                end
`ifdef BOOT_BREAKPOINT_EN
                BRK: begin
                    if (start) begin
                        state    <= RUN;
                        core_run <= 1'b1;
                        bp_hit   <= 1'b0;
                    end
                end
`endif
                default: begin
                    state    <= IDLE;
                    ld_ready <= 1'b0;
                    core_run <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_risc_boot_ctrl.sv
// Scoreboard bench for risc_boot_ctrl; BOOT_BREAKPOINT_EN adds the
// breakpoint scenario.
module tb_risc_boot_ctrl;
    import risc_boot_pkg::*;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int CW = 32;
    localparam int TO = 150;

    logic          clk1 = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          ld_valid = 1'b0;
    logic          ld_last = 1'b0;
    logic [DW-1:0] ld_data = '0;
    logic          core_halted = 1'b0;
    logic          ld_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_wdata;
    logic          core_run;
    logic          done;
    logic          timeout;
    logic          overflow;
    logic [CW-1:0] cycle_count;
    logic [AW:0]   word_count;
`ifdef BOOT_BREAKPOINT_EN
    logic          bp_en = 1'b0;
    logic [AW-1:0] bp_addr = '0;
    logic [AW-1:0] core_pc = '0;
    logic          bp_hit;
`endif

    risc_boot_ctrl #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .CNT_W   (CW),
        .TIMEOUT (TO)
    ) dut (
        .clk1        (clk1),
        .rst         (rst),
        .start       (start),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_data     (ld_data),
        .ld_last     (ld_last),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .core_run    (core_run),
        .core_halted (core_halted),
        .done        (done),
        .timeout     (timeout),
        .overflow    (overflow),
        .cycle_count (cycle_count),
        .word_count  (word_count)
`ifdef BOOT_BREAKPOINT_EN
        ,
        .bp_en       (bp_en),
        .bp_addr     (bp_addr),
        .core_pc     (core_pc),
        .bp_hit      (bp_hit)
`endif
    );

    always #5 clk1 = ~clk1;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  total = 0;
    int  bad = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Monitor: every imem write must match the head of the queue.
    always @(negedge clk1) begin
        if (!rst && imem_we) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL imem_extra actual=%0h:%0h required=none",
                         imem_addr, imem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if (imem_addr !== mon_e.a || imem_wdata !== mon_e.d) begin
                    bad++;
                    $display("FAIL imem_wr actual=%0h:%0h required=%0h:%0h",
                             imem_addr, imem_wdata, mon_e.a, mon_e.d);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic last,
                        input int budget, output bit acc);
        logic rdy;
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        acc      = 1'b0;
        for (int i = 0; i < budget && !acc; i++) begin
            @(negedge clk1);
            rdy = ld_ready;
            tick();
            if (rdy) acc = 1'b1;
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        ld_data  = 32'hdead_beef;
    endtask

    task automatic load_prog(input int n, input logic [DW-1:0] base);
        bit acc;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({AW'(i), base + DW'(i)});
            send(base + DW'(i), (i == n - 1), 4, acc);
            chk("load_acc", acc, 1);
        end
    endtask

    initial begin
        bit acc;

        // Reset state
        repeat (2) @(negedge clk1);
        chk("rst_ready", ld_ready, 0);
        chk("rst_we", imem_we, 0);
        chk("rst_run", core_run, 0);
        chk("rst_flags", {done, timeout, overflow}, 0);
        chk("rst_cnt", cycle_count, 0);
        chk("rst_wc", word_count, 0);
        rst = 1'b0;
        tick();

        // Full program, halt after 120 RUN cycles, stray start ignored
        pulse_start();
        chk("t1_ready", ld_ready, 1);
        load_prog(15, 32'ha000_0000);
        chk("t1_run", core_run, 1);
        repeat (60) tick();
        pulse_start();
        chk("t1_ign_run", core_run, 1);
        chk("t1_ign_wc", word_count, 15);
        repeat (59) tick();
        chk("t1_cnt_pre", cycle_count, 120);
        core_halted = 1'b1;
        tick();
        chk("t1_done", done, 1);
        chk("t1_run_off", core_run, 0);
        chk("t1_cnt", cycle_count, 120);
        chk("t1_tmo", timeout, 0);
        chk("t1_wc", word_count, 15);
        repeat (3) tick();
        chk("t1_cnt_hold", cycle_count, 120);
        core_halted = 1'b0;

        // Timeout after exactly TO RUN cycles
        pulse_start();
        chk("t2_clr_done", done, 0);
        chk("t2_clr_wc", word_count, 0);
        chk("t2_clr_cnt", cycle_count, 0);
        load_prog(3, 32'hb000_0000);
        repeat (TO - 1) tick();
        chk("t2_run_pre", core_run, 1);
        chk("t2_tmo_pre", timeout, 0);
        tick();
        chk("t2_tmo", timeout, 1);
        chk("t2_run_off", core_run, 0);
        chk("t2_done", done, 0);
        chk("t2_cnt", cycle_count, TO);
        repeat (3) tick();
        chk("t2_cnt_hold", cycle_count, TO);

        // Overflow: depth 16, 17 words without last
        pulse_start();
        chk("t3_clr_tmo", timeout, 0);
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back({AW'(i), 32'hc000_0000 + DW'(i)});
            send(32'hc000_0000 + DW'(i), 1'b0, 4, acc);
            chk("t3_acc", acc, 1);
        end
        chk("t3_ready", ld_ready, 0);
        chk("t3_ovf", overflow, 1);
        chk("t3_wc", word_count, 16);
        send(32'hc000_0010, 1'b0, 5, acc);
        chk("t3_rej", acc, 0);
        chk("t3_run", core_run, 0);

        // ld_valid toggling 1,0,1,0 during LOAD
        pulse_start();
        chk("t4_clr_ovf", overflow, 0);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({AW'(i), 32'hd000_0000 + DW'(i)});
            send(32'hd000_0000 + DW'(i), (i == 3), 4, acc);
            chk("t4_acc", acc, 1);
            if (i < 3) begin
                ld_data = 32'hbad0_0000 + DW'(i);
                tick();
            end
        end
        chk("t4_wc", word_count, 4);
        chk("t4_run", core_run, 1);

        // Reset mid-RUN at cycle 30, then clean reload
        repeat (30) tick();
        chk("t5_cnt30", cycle_count, 30);
        rst = 1'b1;
        #1;
        chk("t5_run", core_run, 0);
        chk("t5_flags", {done, timeout, overflow}, 0);
        chk("t5_cnt", cycle_count, 0);
        chk("t5_wc", word_count, 0);
        @(negedge clk1);
        rst = 1'b0;
        tick();
        pulse_start();
        load_prog(2, 32'he000_0000);
        repeat (5) tick();
        core_halted = 1'b1;
        tick();
        core_halted = 1'b0;
        chk("t5_done", done, 1);
        chk("t5_cnt_re", cycle_count, 5);
        chk("t5_wc_re", word_count, 2);

`ifdef BOOT_BREAKPOINT_EN
        // Breakpoint at PC 7, resume with start
        pulse_start();
        load_prog(4, 32'hf000_0000);
        bp_en   = 1'b1;
        bp_addr = 4'd7;
        core_pc = 4'd0;
        repeat (10) tick();
        core_pc = 4'd7;
        tick();
        chk("bp_hit", bp_hit, 1);
        chk("bp_run", core_run, 0);
        chk("bp_cnt", cycle_count, 11);
        repeat (5) tick();
        chk("bp_cnt_hold", cycle_count, 11);
        core_pc = 4'd8;
        pulse_start();
        chk("bp_clr", bp_hit, 0);
        chk("bp_resume", core_run, 1);
        chk("bp_wc", word_count, 4);
        repeat (4) tick();
        core_halted = 1'b1;
        tick();
        core_halted = 1'b0;
        chk("bp_done", done, 1);
        chk("bp_cnt_end", cycle_count, 15);
`endif

        repeat (3) tick();
        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/risc_boot_ctrl.md
Name: risc_boot_ctrl

Overview:
- Synthesizable boot and run controller for the pipelined RISC core; replaces the hand-written testbench preload/run/timeout sequence.
- Streams a program into instruction memory over a valid/ready handshake, then releases the core from halt and counts cycles.
- Reports completion on HLT, or timeout after a parametrised cycle budget.
- Sits between a host/loader port and the core's instruction-memory write port and control inputs.

Parameters:
- ADDR_W, 10, instruction-memory word-address width (depth 2**ADDR_W).
- DATA_W, 32, instruction word width.
- CNT_W, 32, cycle-counter width.
- TIMEOUT, 2000, run-cycle budget before timeout; 0 disables timeout.

Ports:
- clk1  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle pulse; begins a load session (honoured only in IDLE, DONE or TMO).
- ld_valid  in  1  loader word valid.
- ld_ready  out  1  controller accepts word.
- ld_data  in  DATA_W  instruction word.
- ld_last  in  1  marks final word of the program.
- imem_we  out  1  instruction-memory write strobe.
- imem_addr  out  ADDR_W  write address.
- imem_wdata  out  DATA_W  write data.
- core_run  out  1  core enable; 0 holds the core halted with PC forced to 0.
- core_halted  in  1  core has retired HLT.
- done  out  1  program finished via HLT.
- timeout  out  1  cycle budget exhausted.
- overflow  out  1  program longer than memory depth.
- cycle_count  out  CNT_W  cycles spent in RUN.
- word_count  out  ADDR_W+1  words written this session.

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0, except ld_ready=0; counters cleared.
- States: IDLE, LOAD, RUN, DONE, TMO.
- IDLE/DONE/TMO + start:
  - go to LOAD next cycle.
  - clear done, timeout, overflow, cycle_count, word_count; load address = 0.
- LOAD:
  - ld_ready=1; a word transfers when ld_valid&&ld_ready.
  - Each transfer drives imem_we=1, imem_addr=current address and imem_wdata=ld_data, registered, so the write appears 1 cycle after the handshake.
  - Address and word_count then increment.
  - Transfer with ld_last: go to RUN on the following cycle.
  - Transfer at address 2**ADDR_W-1 without ld_last: set overflow, do not wrap, go to TMO. ld_ready drops immediately.
  - ld_valid low: hold the state, no write.
- RUN:
  - core_run=1; cycle_count increments every cycle in RUN, saturating at all-ones.
  - core_halted=1: go to DONE, set done=1; cycle_count freezes, excluding the halt cycle.
  - TIMEOUT!=0 and cycle_count==TIMEOUT-1 without halt: go to TMO, set timeout=1.
  - core_halted and the timeout condition in the same cycle: halt wins (DONE).
- DONE/TMO: core_run=0; status flags sticky until start or rst.
- start outside IDLE/DONE/TMO is ignored.
- ld_ready=0 outside LOAD.
- Reset mid-LOAD: words already written stay in memory. Reset mid-RUN: core_run drops asynchronously.
- core_run deasserts in the same cycle the state leaves RUN. No core write is issued after that.

Optional Feature:
- Macro: BOOT_BREAKPOINT_EN.
- When defined, adds these ports:
  - bp_en in 1.
  - bp_addr in ADDR_W.
  - core_pc in ADDR_W.
  - bp_hit out 1.
- In RUN, bp_en && core_pc==bp_addr drives core_run low next cycle and enters state BRK with bp_hit=1.
- In BRK, start resumes RUN without reload and clears bp_hit.
- The cycle counter pauses in BRK.
- Halt takes priority over a breakpoint in the same cycle.
- When not defined: no ports, no BRK state, identical behaviour otherwise.

Decomposition:
- Package risc_boot_pkg:
  - state enum (IDLE, LOAD, RUN, DONE, TMO, BRK).
  - HLT opcode constant 6'h3f, for bench reference.
  - default widths.
- One sub-module, risc_boot_cnt: saturating cycle counter with enable, clear and terminal-compare output, used for cycle_count and timeout.

Test Plan:
- Reset, start, load 15 words (max-array program, last on word 15), core_halted asserted after 120 RUN cycles → imem writes addr 0..14, word_count=15, done=1, cycle_count=120, timeout=0.
- TIMEOUT=50, core_halted never asserts → timeout=1 after exactly 50 RUN cycles, core_run=0, done=0.
- ADDR_W=2, stream 5 words without ld_last → 4 writes (addr 0..3), overflow=1, state TMO, ld_ready=0 after the 4th word.
- ld_valid toggled 1,0,1,0 during LOAD → writes only on valid cycles, addresses contiguous, no gaps.
- Assert rst mid-RUN at cycle 30 → core_run=0 and all flags 0 immediately. A later start reloads cleanly.
- BOOT_BREAKPOINT_EN, bp_addr=7 → bp_hit=1 when core_pc==7, counter frozen; start resumes and done follows.
